// File: rtl/rr_arb_grant.sv
// rtl/rr_arb_grant.sv - round-robin one-hot grant search starting at rr_ptr
//
// Ports:
//   valid       in   [COUNT]     request vector
//   rr_ptr      in   [ID_WIDTH]  highest-priority requestor this cycle
//   enable      in   1           grants allowed (FIFO not full)
//   grant       out  [COUNT]     one-hot-or-zero grant
//   grant_idx   out  [ID_WIDTH]  encoded index of the granted requestor
//   grant_valid out  1           a grant was issued
module rr_arb_grant #(
  parameter int COUNT    = 4,
  parameter int ID_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic [COUNT-1:0]    valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                enable,
  output logic [COUNT-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);

  logic [COUNT-1:0]   mask;
  logic [2*COUNT-1:0] dbl;
  logic               found;
  int                 idx;

  // The low half holds only requestors at or above rr_ptr, the high half
  // holds all of them; the first set bit of the doubled vector is therefore
  // the first requestor in rr_ptr, rr_ptr+1, ... wrapping order.
  always_comb begin
    mask = '0;
    for (int i = 0; i < COUNT; i++) begin
      mask[i] = (i >= int'(rr_ptr));
    end
    dbl   = {valid, valid & mask};
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < 2 * COUNT; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        idx   = (j >= COUNT) ? j - COUNT : j;
      end
    end
    grant_valid = enable & found;
    grant_idx   = grant_valid ? ID_WIDTH'(idx) : '0;
    grant       = '0;
    for (int k = 0; k < COUNT; k++) begin
      grant[k] = grant_valid && (k == idx);
    end
  end

endmodule

// File: rtl/rr_arb_mux_buffered.sv
// rtl/rr_arb_mux_buffered.sv - round-robin N:1 valid/ready mux feeding a DEPTH-entry FIFO
//
// Ports:
//   CLK                     in   1              clock, rising edge
//   nRST                    in   1              asynchronous active-low reset
//   req_valid_by_requestor  in   [COUNT]        requestor i has data
//   req_data_by_requestor   in   [COUNT][WIDTH] requestor i data
//   req_ready_by_requestor  out  [COUNT]        one-hot-or-zero grant
//   out_valid               out  1              FIFO head valid
//   out_data                out  [WIDTH]        FIFO head data
//   out_id                  out  [ID_WIDTH]     source requestor of FIFO head
//   out_ready               in   1              consumer takes head this cycle
//   occupancy               out  [OCC_WIDTH]    FIFO entry count
module rr_arb_mux_buffered #(
  parameter  int COUNT     = 4,
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 2,
  localparam int ID_WIDTH  = (COUNT > 1) ? $clog2(COUNT) : 1,
  localparam int OCC_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [COUNT-1:0]            req_valid_by_requestor,
  input  logic [COUNT-1:0][WIDTH-1:0] req_data_by_requestor,
  output logic [COUNT-1:0]            req_ready_by_requestor,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [ID_WIDTH-1:0]         out_id,
  input  logic                        out_ready,
  output logic [OCC_WIDTH-1:0]        occupancy
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [OCC_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [WIDTH-1:0]     data_d [DEPTH];
  logic [ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [ID_WIDTH-1:0]  id_d   [DEPTH];

  logic                 full;
  logic                 push;
  logic                 pop;
  logic [ID_WIDTH-1:0]  grant_idx;

  // Full blocks grants outright, so req_ready never depends on out_ready.
  assign full = (count_q == OCC_WIDTH'(DEPTH));
  assign pop  = (count_q != '0) && out_ready;

  rr_arb_grant #(
    .COUNT    (COUNT),
    .ID_WIDTH (ID_WIDTH)
  ) u_grant (
    .valid       (req_valid_by_requestor),
    .rr_ptr      (rr_ptr_q),
    .enable      (!full),
    .grant       (req_ready_by_requestor),
    .grant_idx   (grant_idx),
    .grant_valid (push)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    data_d   = data_q;
    id_d     = id_q;

    if (push) begin
      data_d[tail_q] = req_data_by_requestor[grant_idx];
      id_d[tail_q]   = grant_idx;
      tail_d   = (tail_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : PTR_WIDTH'(tail_q + 1'b1);
      rr_ptr_d = (grant_idx == ID_WIDTH'(COUNT - 1)) ? '0 : ID_WIDTH'(grant_idx + 1'b1);
    end

    if (pop) begin
      head_d = (head_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : PTR_WIDTH'(head_q + 1'b1);
    end

    case ({push, pop})
      2'b10:   count_d = OCC_WIDTH'(count_q + 1'b1);
      2'b01:   count_d = OCC_WIDTH'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = data_q[head_q];
  assign out_id    = id_q[head_q];
  assign occupancy = count_q;

endmodule

// File: tb/tb_rr_arb_mux_buffered.sv
// tb/tb_rr_arb_mux_buffered.sv - self-checking bench for rr_arb_mux_buffered (DEPTH 2 and 3)
module tb_rr_arb_mux_buffered;

  localparam int COUNT = 4;
  localparam int WIDTH = 32;

  logic                        CLK = 1'b0;
  logic                        nrst_a;
  logic                        nrst_b;
  logic [COUNT-1:0]            req_valid;
  logic [COUNT-1:0][WIDTH-1:0] req_data;
  logic                        out_ready;

  logic [COUNT-1:0] a_ready, b_ready;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data,  b_data;
  logic [1:0]       a_id,    b_id;
  logic [1:0]       a_occ,   b_occ;

  logic             sel;
  logic [COUNT-1:0] obs_ready;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;
  logic [1:0]       obs_id;
  logic [1:0]       obs_occ;

  always #5 CLK = ~CLK;

  rr_arb_mux_buffered #(.COUNT(COUNT), .WIDTH(WIDTH), .DEPTH(2)) u_dut_a (
    .CLK                    (CLK),
    .nRST                   (nrst_a),
    .req_valid_by_requestor (req_valid),
    .req_data_by_requestor  (req_data),
    .req_ready_by_requestor (a_ready),
    .out_valid              (a_valid),
    .out_data               (a_data),
    .out_id                 (a_id),
    .out_ready              (out_ready),
    .occupancy              (a_occ)
  );

  rr_arb_mux_buffered #(.COUNT(COUNT), .WIDTH(WIDTH), .DEPTH(3)) u_dut_b (
    .CLK                    (CLK),
    .nRST                   (nrst_b),
    .req_valid_by_requestor (req_valid),
    .req_data_by_requestor  (req_data),
    .req_ready_by_requestor (b_ready),
    .out_valid              (b_valid),
    .out_data               (b_data),
    .out_id                 (b_id),
    .out_ready              (out_ready),
    .occupancy              (b_occ)
  );

  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_data  = sel ? b_data  : a_data;
  assign obs_id    = sel ? b_id    : a_id;
  assign obs_occ   = sel ? b_occ   : a_occ;

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered list of beats plus a "who goes first" index.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               id;
  } ent_t;

  ent_t q[$];
  int   m_ptr;
  int   m_depth;
  int   dut_g;
  int   last_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [COUNT-1:0] v);
    if (q.size() >= m_depth) return -1;
    for (int k = 0; k < COUNT; k++) begin
      if (v[(m_ptr + k) % COUNT]) return (m_ptr + k) % COUNT;
    end
    return -1;
  endfunction

  task automatic step(input logic [COUNT-1:0] v, input logic rdy);
    int               g;
    logic [COUNT-1:0] exp_ready;
    req_valid = v;
    for (int i = 0; i < COUNT; i++) req_data[i] = $urandom;
    out_ready = rdy;
    @(negedge CLK);
    g         = model_grant(v);
    exp_ready = (g >= 0) ? COUNT'(1 << g) : '0;
    chk("req_ready", obs_ready, exp_ready);
    chk("out_valid", obs_valid, q.size() != 0);
    chk("occupancy", obs_occ, q.size());
    if (q.size() != 0) begin
      chk("out_data", obs_data, q[0].d);
      chk("out_id", obs_id, q[0].id);
    end
    dut_g = -1;
    for (int i = 0; i < COUNT; i++) if (obs_ready[i]) dut_g = i;
    last_id = obs_valid ? int'(obs_id) : -1;
    @(posedge CLK);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{req_data[g], g});
      m_ptr = (g + 1) % COUNT;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = '1;
    out_ready = 1'b1;
    if (sel) nrst_b = 1'b0; else nrst_a = 1'b0;
    q.delete();
    m_ptr = 0;
    @(negedge CLK);
    chk("rst_out_valid", obs_valid, 1'b0);
    chk("rst_occupancy", obs_occ, 0);
    chk("rst_out_data", obs_data, 0);
    chk("rst_out_id", obs_id, 0);
    chk("rst_req_ready", obs_ready, 4'b0001);
    @(posedge CLK);
    #1;
    if (sel) nrst_b = 1'b1; else nrst_a = 1'b1;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int sp_exp[4] = '{1, 3, 1, 3};
  int ntx;

  initial begin
    sel       = 1'b0;
    nrst_a    = 1'b0;
    nrst_b    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    m_depth   = 2;
    m_ptr     = 0;
    dut_g     = -1;
    last_id   = -1;

    // Reset then round-robin order with all requestors active.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1);
      chk("rr_order_grant", dut_g, rr_exp[k]);
      if (k >= 1) chk("rr_order_id", last_id, k - 1);
    end

    // Sparse requests from pointer 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'b1010, 1'b1);
      chk("sparse_grant", dut_g, sp_exp[k]);
      if (k >= 1) chk("sparse_id", last_id, sp_exp[k-1]);
    end

    // Fill to full, withdraw requestor 2 while full, single pop.
    do_reset();
    step(4'b1111, 1'b0);
    chk("fill_grant0", dut_g, 0);
    step(4'b1111, 1'b0);
    chk("fill_grant1", dut_g, 1);
    step(4'b1111, 1'b0);
    chk("full_no_grant", dut_g, -1);
    step(4'b0100, 1'b0);
    chk("withdraw_no_grant", dut_g, -1);
    step(4'b1111, 1'b1);
    chk("pop_no_grant", dut_g, -1);
    chk("pop_head_id", last_id, 0);
    step(4'b1111, 1'b0);
    chk("after_pop_grant", dut_g, 2);

    // Asynchronous reset mid-cycle with two entries held.
    #3;
    nrst_a = 1'b0;
    #1;
    chk("async_out_valid", a_valid, 1'b0);
    chk("async_occupancy", a_occ, 0);
    q.delete();
    m_ptr = 0;
    @(posedge CLK);
    #1;
    nrst_a = 1'b1;
    step(4'b1111, 1'b1);
    chk("post_async_grant", dut_g, 0);

    // Randomised traffic on DEPTH=2.
    for (int k = 0; k < 300; k++) step(COUNT'($urandom), 1'($urandom));

    // DEPTH=3: wrap with alternating drain, then random traffic.
    sel     = 1'b1;
    m_depth = 3;
    do_reset();
    ntx = 0;
    for (int k = 0; k < 40 && ntx < 10; k++) begin
      step(4'b1111, 1'(k % 2));
      if (dut_g >= 0) ntx++;
    end
    chk("wrap_transfers", ntx, 10);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1);
    chk("wrap_drained", b_occ, 0);
    for (int k = 0; k < 400; k++) step(COUNT'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
